// File: rtl/serializador_palabra.sv
// MSB-first parallel-to-serial transmitter; each bit held DIV cycles, word period W*DIV+2 cycles.
// First bit appears the cycle after Inicio is accepted; Listo gates acceptance; Fin pulses once per completed word.
module serializador_palabra #(
  parameter int W   = 23,
  parameter int DIV = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Inicio,
  input  logic [W-1:0] Entrada,
  output logic         Listo,
  output logic         Bit_Salida,
  output logic         Valido,
  output logic         Fin
);

  localparam int BW = $clog2(W + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            listo_q, listo_d;
  logic            bit_q, bit_d;
  logic            valido_q, valido_d;
  logic            fin_q, fin_d;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;

    case (state_q)
      IDLE: begin
        if (Inicio) begin
          sr_d      = Entrada;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sr_d      = {sr_q[W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with state_q.
    listo_d  = (state_d == IDLE);
    valido_d = (state_d == SHIFT);
    fin_d    = (state_d == DONE);
    bit_d    = (state_d == SHIFT) && sr_d[W-1];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      listo_q   <= 1'b1;
      valido_q  <= 1'b0;
      fin_q     <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      listo_q   <= listo_d;
      valido_q  <= valido_d;
      fin_q     <= fin_d;
      bit_q     <= bit_d;
    end
  end

  assign Listo      = listo_q;
  assign Valido     = valido_q;
  assign Fin        = fin_q;
  assign Bit_Salida = bit_q;

endmodule

// File: doc/serializador_palabra.md
# serializador_palabra

- Parallel-to-serial transmitter for W-bit datapath words, MSB first, each bit held for DIV clock cycles.
- Sits downstream of the datapath's enabled pipeline registers and drains one registered word onto a single-bit output with a valid flag.
- Signals word completion with a one-cycle pulse, so the producer can load the next word.

## Interface
Parameters:
- W, 23, word width in bits; W ≥ 2.
- DIV, 4, clock cycles each bit is held; DIV ≥ 1.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; forces idle immediately.
- Inicio  input  1  load strobe; sampled only when Listo=1.
- Entrada  input  W  word to transmit; sampled on the edge where Inicio is accepted.
- Listo  output  1  high in IDLE only; block can accept a word.
- Bit_Salida  output  1  current serial bit; 0 when not in SHIFT.
- Valido  output  1  high while Bit_Salida carries a data bit.
- Fin  output  1  one-cycle pulse after the last bit.

## Operation
- Internal state:
  - Shift register SR[W-1:0].
  - Bit counter, width $clog2(W+1).
  - Divider counter, width $clog2(DIV+1).
  - FSM with states IDLE, SHIFT, DONE.
- Reset (async, any state, any cycle):
  - State → IDLE; SR, bit counter and divider counter → 0.
  - Bit_Salida=0, Valido=0, Fin=0, Listo=1 while Reset is high and after release.
- IDLE:
  - Listo=1, Valido=0, Fin=0, Bit_Salida=0.
  - Inicio=1 at an edge: SR←Entrada, bit counter←0, divider←0, state→SHIFT.
- SHIFT:
  - Valido=1, Bit_Salida=SR[W-1], Listo=0.
  - Divider increments each cycle. When it reaches DIV-1 it clears, SR shifts left by one with 0 filling the LSB, and the bit counter increments.
  - When the bit counter = W-1 and the divider = DIV-1, state→DONE.
- DONE:
  - Exactly one cycle: Fin=1, Valido=0, Bit_Salida=0, Listo=0; then → IDLE.
- Inicio outside IDLE (SHIFT or DONE) is ignored, with no queuing and no effect on the word in flight.
- Entrada changes after acceptance do not affect transmission.
- Held Inicio=1 in IDLE restarts immediately on each return to IDLE (back-to-back words).
- Outputs are registered or decoded from registered state only; there is no combinational path from Inicio or Entrada to any output.

## Timing
- Edge 0 accepts Inicio. Valido and the first bit (Entrada[W-1]) are visible in the cycle after edge 0.
- Bit k (k=0 is the MSB) is valid during cycles 1+k·DIV through (k+1)·DIV, relative to edge 0.
- Fin is high in cycle W·DIV+1.
- Listo is high again from cycle W·DIV+2; the earliest next acceptance is the edge ending that cycle.
- Word period is W·DIV+2 cycles; with defaults, 94 cycles.
- DIV=1 degenerates to one bit per cycle with no divider wait.
- Reset asserted mid-SHIFT drops Valido within the same cycle (asynchronous). Fin is never generated for an aborted word.
- Reset released coincident with Inicio=1: the first edge after release may accept the word; the bench must not depend on it.

## Test plan
- Reset then idle: assert Reset, release, hold Inicio=0 for 10 cycles → Listo=1, Valido=0, Fin=0 and Bit_Salida=0 throughout.
- Single word, defaults: Entrada=23'h400001, Inicio pulse → Valido high for 92 cycles; Bit_Salida=1 for the first 4 cycles and the last 4; Fin pulse in cycle 93; Listo high in cycle 94.
- Alternating pattern, DIV=1: Entrada=23'h2AAAAA → Bit_Salida=0,1,0,1,…,0 over cycles 1–23; Fin in cycle 24.
- Inicio while busy: start 23'h7FFFFF, pulse Inicio with Entrada=0 at cycle 40 → transmission stays all-ones and completes unchanged; only one Fin.
- Back-to-back: hold Inicio=1 with Entrada=23'h000001 then 23'h400000 → second word accepted at the edge ending cycle 94; Fin pulses 94 cycles apart.
- Async reset mid-word: assert Reset mid-cycle at cycle 30 → Valido=0 and Listo=1 before the next edge; no Fin; a new word after release transmits correctly.
